// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, the stall vector
// type and encodings, ALU and divide opcodes, the ID->EX bus layout and the
// divider FSM state type.
package ex_stage_pkg;

  localparam int DATA_W       = 32;
  localparam int ID_TO_EX_WD  = 146;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_WD     = 6;

  // Stall vector: one bit per pipeline stage, index 2 = EX, index 3 = MEM.
  typedef logic [STALL_WD-1:0] StallBus;
  localparam int   STG_EX  = 2;
  localparam int   STG_MEM = 3;
  localparam logic Stop    = 1'b1;
  localparam logic NoStop  = 1'b0;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MFHI = 4'd12;
  localparam logic [3:0] ALU_MFLO = 4'd13;
  localparam logic [3:0] ALU_MTHI = 4'd14;
  localparam logic [3:0] ALU_MTLO = 4'd15;

  localparam logic [1:0] DIV_NONE = 2'b00;
  localparam logic [1:0] DIV_S    = 2'b01;
  localparam logic [1:0] DIV_U    = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [1:0]  div_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] store_data;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
  } id_ex_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset (FSM only)
//   start        a divide is present in EX
//   is_signed    1 = DIV (signed), 0 = DIVU
//   a, b         dividend, divisor
//   ack          EX advances this cycle; commits a finished result
//   busy         stall request (start seen in IDLE, or iterating)
//   done         result valid on q/r
//   q, r         sign-corrected quotient and remainder
// Divide by zero finishes immediately with q = all ones, r = a.
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DIV_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);

  localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_e state_r, state_nxt;

  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rem_r, quo_r, dvs_r;
  logic              neg_q_r, neg_r_r;

  logic              sign_a, sign_b, b_zero;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] rem_sub;
  logic              fits;

  // Magnitude of a two's-complement value when neg is set; the most negative
  // value maps to its correct unsigned magnitude 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic                     neg);
    return neg ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  assign sign_a = is_signed & a[DATA_W-1];
  assign sign_b = is_signed & b[DATA_W-1];
  assign b_zero = (b == '0);

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits. rem_sub is exact whenever fits=1
  // because the partial remainder is always below the divisor.
  assign shifted = {rem_r, quo_r[DATA_W-1]};
  assign fits    = (shifted >= {1'b0, dvs_r});
  assign rem_sub = shifted[DATA_W-1:0] - dvs_r;

  always_ff @(posedge clk) begin
    if (rst) state_r <= DIV_IDLE;
    else     state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      DIV_IDLE: if (start) state_nxt = b_zero ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (cnt_r == CNT_LAST) state_nxt = DIV_DONE;
      DIV_DONE: if (ack) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = ((state_r == DIV_IDLE) && start) || (state_r == DIV_RUN);
    done = (state_r == DIV_DONE);
  end

  // Datapath: operand latch on start, one shift/subtract per RUN cycle.
  always_ff @(posedge clk) begin
    if (state_r == DIV_IDLE && start) begin
      cnt_r <= '0;
      if (b_zero) begin
        quo_r   <= '1;
        rem_r   <= a;
        dvs_r   <= '0;
        neg_q_r <= 1'b0;
        neg_r_r <= 1'b0;
      end else begin
        quo_r   <= mag(a, sign_a);
        rem_r   <= '0;
        dvs_r   <= mag(b, sign_b);
        neg_q_r <= sign_a ^ sign_b;
        neg_r_r <= sign_a;
      end
    end else if (state_r == DIV_RUN) begin
      cnt_r <= cnt_r + 1'b1;
      rem_r <= fits ? rem_sub : shifted[DATA_W-1:0];
      quo_r <= {quo_r[DATA_W-2:0], fits};
    end
  end

  assign q = neg_q_r ? DATA_W'(-quo_r) : quo_r;
  assign r = neg_r_r ? DATA_W'(-rem_r) : rem_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipeline register, ALU, data SRAM request, HI/LO
// registers and the iterative divider with its stall request.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             stall vector (bit 2 = EX, bit 3 = MEM)
//   id_to_ex_bus      decoded instruction from ID
//   ex_to_mem_bus     {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_id_bus      forwarding {rf_we, rf_waddr, ex_result}
//   ex_is_load        load in EX, for the load-use stall in ID
//   stallreq_for_ex   divider busy
//   data_sram_*       data SRAM request
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  StallBus                 stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  id_ex_t      id_ex_p0;
  logic [31:0] hi_r, lo_r;
  logic [31:0] ex_result;
  logic        ex_go;
  logic        div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [3:0]  unused_stall_bits;

  assign unused_stall_bits = {stall[5:4], stall[1:0]};
  assign ex_go = (stall[STG_EX] == NoStop);

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (rst)
      id_ex_p0 <= '0;
    else if (stall[STG_EX] == Stop && stall[STG_MEM] == NoStop)
      id_ex_p0 <= '0;
    else if (stall[STG_EX] == NoStop)
      id_ex_p0 <= id_ex_t'(id_to_ex_bus);
  end

  // ALU: 32-bit wrap-around, no overflow trap.
  always_comb begin
    logic signed [31:0] a_s, b_s;
    a_s       = $signed(id_ex_p0.src_a);
    b_s       = $signed(id_ex_p0.src_b);
    ex_result = '0;
    case (id_ex_p0.alu_op)
      ALU_ADD:  ex_result = id_ex_p0.src_a + id_ex_p0.src_b;
      ALU_SUB:  ex_result = id_ex_p0.src_a - id_ex_p0.src_b;
      ALU_AND:  ex_result = id_ex_p0.src_a & id_ex_p0.src_b;
      ALU_OR:   ex_result = id_ex_p0.src_a | id_ex_p0.src_b;
      ALU_XOR:  ex_result = id_ex_p0.src_a ^ id_ex_p0.src_b;
      ALU_NOR:  ex_result = ~(id_ex_p0.src_a | id_ex_p0.src_b);
      ALU_SLT:  ex_result = {31'b0, (a_s < b_s)};
      ALU_SLTU: ex_result = {31'b0, (id_ex_p0.src_a < id_ex_p0.src_b)};
      ALU_SLL:  ex_result = id_ex_p0.src_b << id_ex_p0.src_a[4:0];
      ALU_SRL:  ex_result = id_ex_p0.src_b >> id_ex_p0.src_a[4:0];
      ALU_SRA:  ex_result = 32'(b_s >>> id_ex_p0.src_a[4:0]);
      ALU_LUI:  ex_result = {id_ex_p0.src_b[15:0], 16'h0};
      ALU_MFHI: ex_result = hi_r;
      ALU_MFLO: ex_result = lo_r;
      default:  ex_result = id_ex_p0.src_a;  // MTHI / MTLO pass a through
    endcase
  end

  div_iter #(
    .DATA_W   (32),
    .DIV_ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (id_ex_p0.div_op != DIV_NONE),
    .is_signed (id_ex_p0.div_op == DIV_S),
    .a         (id_ex_p0.src_a),
    .b         (id_ex_p0.src_b),
    .ack       (ex_go),
    .busy      (div_busy),
    .done      (div_done),
    .q         (div_q),
    .r         (div_r)
  );

  // HI/LO: divide commit and MTHI/MTLO happen only as EX advances, and a
  // single instruction occupies EX, so the branches never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (ex_go) begin
      if (div_done) begin
        lo_r <= div_q;
        hi_r <= div_r;
      end else if (id_ex_p0.alu_op == ALU_MTHI) begin
        hi_r <= id_ex_p0.src_a;
      end else if (id_ex_p0.alu_op == ALU_MTLO) begin
        lo_r <= id_ex_p0.src_a;
      end
    end
  end

  assign stallreq_for_ex = div_busy;

  assign ex_to_mem_bus = {id_ex_p0.pc, id_ex_p0.data_ram_en, id_ex_p0.data_ram_wen,
                          id_ex_p0.sel_rf_res, id_ex_p0.rf_we, id_ex_p0.rf_waddr, ex_result};
  assign ex_to_id_bus  = {id_ex_p0.rf_we, id_ex_p0.rf_waddr, ex_result};
  assign ex_is_load    = id_ex_p0.data_ram_en & (id_ex_p0.data_ram_wen == 4'h0) & id_ex_p0.rf_we;

  assign data_sram_en    = id_ex_p0.data_ram_en;
  assign data_sram_wen   = id_ex_p0.data_ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = id_ex_p0.store_data;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  StallBus                 stall;
  StallBus                 ext_stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    ex_is_load;
  logic                    stallreq_for_ex;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [75:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] pc_v;

  // Stall controller model: a busy divider stops IF/ID/EX and lets MEM run.
  assign stall = stallreq_for_ex ? 6'b000111 : ext_stall;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [145:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                      input logic [1:0] dop, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] sd,
                                      input logic en, input logic [3:0] wen,
                                      input logic sel, input logic we, input logic [4:0] wa);
    return {pc, op, dop, a, b, sd, en, wen, sel, we, wa};
  endfunction

  function automatic logic [75:0] mem_exp(input logic [31:0] pc, input logic en,
                                          input logic [3:0] wen, input logic sel,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] res);
    return {pc, en, wen, sel, we, wa, res};
  endfunction

  task automatic push(input string tag, input logic [75:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic check_mem();
    logic [75:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, ex_to_mem_bus, e);
  endtask

  task automatic issue(input string tag, input logic [145:0] bus, input logic [75:0] exp);
    id_to_ex_bus = bus;
    push(tag, exp);
    step();
    check_mem();
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res);
    issue(tag, mk(pc_v, op, DIV_NONE, a, b, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7),
          mem_exp(pc_v, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, res));
    pc_v = pc_v + 32'd4;
  endtask

  // Count stall cycles of a divide already present in EX; bounded wait.
  task automatic count_stall(output int cnt, output logic dirty);
    cnt   = 0;
    dirty = 1'b0;
    while (stallreq_for_ex === 1'b1 && cnt < 100) begin
      cnt++;
      step();
      if (stallreq_for_ex === 1'b1) dirty = dirty | (|ex_to_mem_bus);
    end
  endtask

  initial begin
    int   cnt;
    logic dirty;

    rst          = 1'b1;
    ext_stall    = '0;
    id_to_ex_bus = '0;
    pc_v         = 32'h0000_0040;
    step();
    step();
    chk("rst_mem_bus", ex_to_mem_bus, 76'h0);
    chk("rst_id_bus", {38'h0, ex_to_id_bus}, 76'h0);
    chk("rst_sram", {7'h0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'h0);
    chk("rst_flags", {74'h0, stallreq_for_ex, ex_is_load}, 76'h0);
    rst = 1'b0;

    // ADD wraps without trapping
    issue("add_wrap", mk(32'h100, ALU_ADD, DIV_NONE, 32'h7FFF_FFFF, 32'h1, 32'h0,
                         1'b0, 4'h0, 1'b0, 1'b1, 5'd5),
          mem_exp(32'h100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h8000_0000));
    chk("add_fwd", {38'h0, ex_to_id_bus}, {38'h0, 1'b1, 5'd5, 32'h8000_0000});

    // SW
    issue("sw_bus", mk(32'h104, ALU_ADD, DIV_NONE, 32'h1000, 32'h4, 32'hDEAD_BEEF,
                       1'b1, 4'hF, 1'b0, 1'b0, 5'd0),
          mem_exp(32'h104, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h1004));
    chk("sw_sram", {7'h0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
        {7'h0, 1'b1, 4'hF, 32'h1004, 32'hDEAD_BEEF});
    chk("sw_not_load", {75'h0, ex_is_load}, 76'h0);

    // LW
    issue("lw_bus", mk(32'h108, ALU_ADD, DIV_NONE, 32'h2000, 32'h8, 32'h0,
                       1'b1, 4'h0, 1'b1, 1'b1, 5'd3),
          mem_exp(32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h2008));
    chk("lw_is_load", {75'h0, ex_is_load}, 76'h1);

    // ALU coverage
    alu_vec("sub",    ALU_SUB,  32'h5,         32'h7,         32'hFFFF_FFFE);
    alu_vec("and",    ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_vec("or",     ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu_vec("xor",    ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_vec("nor",    ALU_NOR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu_vec("slt_lt", ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1);
    alu_vec("slt_ge", ALU_SLT,  32'h1,         32'hFFFF_FFFF, 32'h0);
    alu_vec("sltu",   ALU_SLTU, 32'h1,         32'hFFFF_FFFF, 32'h1);
    alu_vec("sll",    ALU_SLL,  32'h24,        32'h1,         32'h10);
    alu_vec("srl",    ALU_SRL,  32'h4,         32'h8000_0000, 32'h0800_0000);
    alu_vec("sra",    ALU_SRA,  32'h4,         32'h8000_0000, 32'hF800_0000);
    alu_vec("lui",    ALU_LUI,  32'h0,         32'h0001_1234, 32'h1234_0000);
    alu_vec("mthi",   ALU_MTHI, 32'h55,        32'h0,         32'h55);
    alu_vec("mfhi",   ALU_MFHI, 32'h0,         32'h0,         32'h55);
    alu_vec("mtlo",   ALU_MTLO, 32'h66,        32'h0,         32'h66);
    alu_vec("mflo",   ALU_MFLO, 32'h0,         32'h0,         32'h66);

    // Signed DIV -7 / 2, then MFLO and MFHI
    issue("div_bus", mk(32'h200, ALU_ADD, DIV_S, 32'hFFFF_FFF9, 32'h2, 32'h0,
                        1'b0, 4'h0, 1'b0, 1'b0, 5'd0),
          mem_exp(32'h200, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFB));
    id_to_ex_bus = mk(32'h204, ALU_MFLO, DIV_NONE, 32'h0, 32'h0, 32'h0,
                      1'b0, 4'h0, 1'b0, 1'b1, 5'd8);
    count_stall(cnt, dirty);
    chk("div_stall_cycles", 76'(cnt), 76'd33);
    chk("div_bubbles", {75'h0, dirty}, 76'h0);
    issue("div_mflo", mk(32'h204, ALU_MFLO, DIV_NONE, 32'h0, 32'h0, 32'h0,
                         1'b0, 4'h0, 1'b0, 1'b1, 5'd8),
          mem_exp(32'h204, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hFFFF_FFFD));
    issue("div_mfhi", mk(32'h208, ALU_MFHI, DIV_NONE, 32'h0, 32'h0, 32'h0,
                         1'b0, 4'h0, 1'b0, 1'b1, 5'd9),
          mem_exp(32'h208, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'hFFFF_FFFF));

    // DIVU by zero
    issue("divu0_bus", mk(32'h300, ALU_ADD, DIV_U, 32'h7, 32'h0, 32'h0,
                          1'b0, 4'h0, 1'b0, 1'b0, 5'd0),
          mem_exp(32'h300, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h7));
    id_to_ex_bus = mk(32'h304, ALU_MFLO, DIV_NONE, 32'h0, 32'h0, 32'h0,
                      1'b0, 4'h0, 1'b0, 1'b1, 5'd8);
    count_stall(cnt, dirty);
    chk("divu0_stall_cycles", 76'(cnt), 76'd1);
    issue("divu0_mflo", mk(32'h304, ALU_MFLO, DIV_NONE, 32'h0, 32'h0, 32'h0,
                           1'b0, 4'h0, 1'b0, 1'b1, 5'd8),
          mem_exp(32'h304, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'hFFFF_FFFF));
    issue("divu0_mfhi", mk(32'h308, ALU_MFHI, DIV_NONE, 32'h0, 32'h0, 32'h0,
                           1'b0, 4'h0, 1'b0, 1'b1, 5'd9),
          mem_exp(32'h308, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h7));

    // Reset in the middle of a DIV
    issue("rstdiv_bus", mk(32'h400, ALU_ADD, DIV_S, 32'd100, 32'd3, 32'h0,
                           1'b0, 4'h0, 1'b0, 1'b0, 5'd0),
          mem_exp(32'h400, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd103));
    id_to_ex_bus = mk(32'h404, ALU_MFHI, DIV_NONE, 32'h0, 32'h0, 32'h0,
                      1'b0, 4'h0, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 11; i++) step();
    chk("rstdiv_running", {75'h0, stallreq_for_ex}, 76'h1);
    rst = 1'b1;
    step();
    chk("rstdiv_stallreq", {75'h0, stallreq_for_ex}, 76'h0);
    chk("rstdiv_mem_bus", ex_to_mem_bus, 76'h0);
    rst = 1'b0;
    issue("rstdiv_mfhi", mk(32'h404, ALU_MFHI, DIV_NONE, 32'h0, 32'h0, 32'h0,
                            1'b0, 4'h0, 1'b0, 1'b1, 5'd9),
          mem_exp(32'h404, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h0));
    issue("rstdiv_mflo", mk(32'h408, ALU_MFLO, DIV_NONE, 32'h0, 32'h0, 32'h0,
                            1'b0, 4'h0, 1'b0, 1'b1, 5'd8),
          mem_exp(32'h408, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h0));

    // EX and MEM both stopped: register holds
    issue("hold_add", mk(32'h500, ALU_ADD, DIV_NONE, 32'h1, 32'h2, 32'h0,
                         1'b0, 4'h0, 1'b0, 1'b1, 5'd4),
          mem_exp(32'h500, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h3));
    ext_stall = 6'b001111;
    issue("hold_kept", mk(32'h504, ALU_SUB, DIV_NONE, 32'h9, 32'h2, 32'h0,
                          1'b0, 4'h0, 1'b0, 1'b1, 5'd6),
          mem_exp(32'h500, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h3));

    // EX stopped, MEM running: two bubbles, then SLT enters
    ext_stall = 6'b000111;
    issue("bubble_1", mk(32'h600, ALU_SLT, DIV_NONE, 32'hFFFF_FFFF, 32'h1, 32'h0,
                         1'b0, 4'h0, 1'b0, 1'b1, 5'd10), 76'h0);
    step();
    push("bubble_2", 76'h0);
    check_mem();
    ext_stall = '0;
    issue("slt_after_bubble", mk(32'h600, ALU_SLT, DIV_NONE, 32'hFFFF_FFFF, 32'h1, 32'h0,
                                 1'b0, 4'h0, 1'b0, 1'b1, 5'd10),
          mem_exp(32'h600, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
